// File: rtl/sm_als_ctrl_pkg.sv
// Shared definitions for the ambient light sensor SPI sequencer: state encodings,
// frame field positions and the value-extraction helper.
package sm_als_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StShift = 3'd2,
    StHold  = 3'd3,
    StGap   = 3'd4
  } state_e;

  localparam int unsigned ALS_FRAME_LEN = 16;
  localparam int unsigned ALS_DATA_MSB  = 12;
  localparam int unsigned ALS_DATA_LSB  = 5;
  localparam int unsigned ALS_LEAD_MSB  = 15;
  localparam int unsigned ALS_LEAD_LSB  = 13;
  localparam int unsigned AVG_SUM_W     = 10;

  function automatic logic [7:0] alsData(input logic [ALS_FRAME_LEN-1:0] frame);
    return frame[ALS_DATA_MSB:ALS_DATA_LSB];
  endfunction

endpackage

// File: rtl/sm_als_avg.sv
// Four-sample box average of light values: the incoming sample plus the three
// previous ones; history advances on push and clears on reset.
module sm_als_avg
  import sm_als_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] sample,
  output logic [7:0] avg
);

  logic [7:0]           h0_q, h1_q, h2_q;
  logic [AVG_SUM_W-1:0] sum;

  // Average includes the sample being pushed so the result is ready on the same edge.
  assign sum = AVG_SUM_W'(sample) + AVG_SUM_W'(h0_q) + AVG_SUM_W'(h1_q) + AVG_SUM_W'(h2_q);
  assign avg = 8'(sum >> 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h0_q <= 8'h00;
      h1_q <= 8'h00;
      h2_q <= 8'h00;
    end else if (push) begin
      h0_q <= sample;
      h1_q <= h0_q;
      h2_q <= h1_q;
    end
  end

endmodule

// File: rtl/sm_als_ctrl.sv
// SPI read sequencer for the ADC081S021-class light sensor: single-shot and auto polling.
// Optional SM_ALS_CTRL_AVG_EN replaces the raw value with a 4-sample box average.
module sm_als_ctrl
  import sm_als_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned POLL_GAP = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       auto,
  output logic       busy,
  output logic       valid,
  output logic [7:0] data,
  output logic       frameErr,
  output logic       alsCS,
  output logic       alsSCK,
  input  logic       alsSDO
);

  localparam logic [7:0]  DivLast = 8'(CLK_DIV - 1);
  localparam logic [19:0] GapLast = 20'(POLL_GAP);
  localparam logic [3:0]  BitLast = 4'(ALS_FRAME_LEN - 1);

  state_e                   state_q, state_d;
  logic [7:0]               divCnt_q, divCnt_d;
  logic [3:0]               bitCnt_q, bitCnt_d;
  logic [19:0]              gapCnt_q, gapCnt_d;
  logic [ALS_FRAME_LEN-1:0] frame_q, frame_d;
  logic                     cs_q, cs_d, sck_q, sck_d;
  logic                     busy_q, busy_d, valid_q, valid_d;
  logic                     frameErr_q, frameErr_d;
  logic [7:0]               data_q, data_d;
  logic                     divLast, frameDone;
  logic [7:0]               rawData, dataNext;

  assign divLast   = (divCnt_q == DivLast);
  assign frameDone = (state_q == StHold) && divLast;
  assign rawData   = alsData(frame_q);

`ifdef SM_ALS_CTRL_AVG_EN
  sm_als_avg uAvg (
    .clk    (clk),
    .rst    (rst),
    .push   (frameDone),
    .sample (rawData),
    .avg    (dataNext)
  );
`else
  assign dataNext = rawData;
`endif

  always_comb begin
    state_d    = state_q;
    divCnt_d   = divCnt_q;
    bitCnt_d   = bitCnt_q;
    gapCnt_d   = gapCnt_q;
    frame_d    = frame_q;
    cs_d       = cs_q;
    sck_d      = sck_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    frameErr_d = frameErr_q;
    data_d     = data_q;

    unique case (state_q)
      StIdle: begin
        if (start || auto) begin
          state_d  = StSetup;
          divCnt_d = 8'h00;
          cs_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end
      StSetup: begin
        if (divLast) begin
          state_d  = StShift;
          divCnt_d = 8'h00;
          bitCnt_d = 4'h0;
          sck_d    = 1'b0;
        end else begin
          divCnt_d = divCnt_q + 8'h01;
        end
      end
      StShift: begin
        if (divLast) begin
          divCnt_d = 8'h00;
          if (!sck_q) begin
            // SDO is captured on the edge that raises SCK.
            sck_d   = 1'b1;
            frame_d = {frame_q[ALS_FRAME_LEN-2:0], alsSDO};
          end else if (bitCnt_q == BitLast) begin
            state_d = StHold;
          end else begin
            sck_d    = 1'b0;
            bitCnt_d = bitCnt_q + 4'h1;
          end
        end else begin
          divCnt_d = divCnt_q + 8'h01;
        end
      end
      StHold: begin
        if (divLast) begin
          divCnt_d   = 8'h00;
          cs_d       = 1'b1;
          busy_d     = 1'b0;
          valid_d    = 1'b1;
          data_d     = dataNext;
          frameErr_d = |frame_q[ALS_LEAD_MSB:ALS_LEAD_LSB];
          gapCnt_d   = 20'h0;
          state_d    = auto ? StGap : StIdle;
        end else begin
          divCnt_d = divCnt_q + 8'h01;
        end
      end
      StGap: begin
        // One extra cycle after the count is the GAP->SETUP hop.
        if (!auto) begin
          state_d = StIdle;
        end else if (gapCnt_q == GapLast) begin
          state_d  = StSetup;
          divCnt_d = 8'h00;
          cs_d     = 1'b0;
          busy_d   = 1'b1;
        end else begin
          gapCnt_d = gapCnt_q + 20'h1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      divCnt_q   <= 8'h00;
      bitCnt_q   <= 4'h0;
      gapCnt_q   <= 20'h0;
      frame_q    <= '0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b1;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      frameErr_q <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      divCnt_q   <= divCnt_d;
      bitCnt_q   <= bitCnt_d;
      gapCnt_q   <= gapCnt_d;
      frame_q    <= frame_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      frameErr_q <= frameErr_d;
      data_q     <= data_d;
    end
  end

  assign alsCS    = cs_q;
  assign alsSCK   = sck_q;
  assign busy     = busy_q;
  assign valid    = valid_q;
  assign data     = data_q;
  assign frameErr = frameErr_q;

endmodule
